// File: rtl/traffic_sequencer_pkg.sv
// Shared definitions for the intersection sequencer: phase codes,
// lamp encodings and duration-register select indices.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_NSG  = 3'b001,
    ST_NSY  = 3'b010,
    ST_EWG  = 3'b011,
    ST_EWY  = 3'b100,
    ST_PED  = 3'b101
  } state_t;

  // Lamp bit order is {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] CFG_NSG = 2'd0;
  localparam logic [1:0] CFG_NSY = 2'd1;
  localparam logic [1:0] CFG_EWG = 2'd2;
  localparam logic [1:0] CFG_EWY = 2'd3;

endpackage

// File: rtl/traffic_sequencer_if.sv
// Control and lamp bundle between the sequencer and whatever drives it.
// The slave side is the sequencer; the master side issues requests and
// configuration writes and watches the lamps.
interface traffic_sequencer_if #(
  parameter int W = 8
);

  logic         start;
  logic         stop;
  logic         ped_req;
  logic         cfg_we;
  logic [1:0]   cfg_sel;
  logic [W-1:0] cfg_val;
  logic [2:0]   phase;
  logic [2:0]   ns_light;
  logic [2:0]   ew_light;
  logic         walk;
  logic         ped_pending;

  modport master (
    output start, stop, ped_req, cfg_we, cfg_sel, cfg_val,
    input  phase, ns_light, ew_light, walk, ped_pending
  );

  modport slave (
    input  start, stop, ped_req, cfg_we, cfg_sel, cfg_val,
    output phase, ns_light, ew_light, walk, ped_pending
  );

endinterface

// File: rtl/traffic_sequencer_phase_timer.sv
// Down counter that times the current phase. A load sets the count;
// otherwise it counts down and parks at zero, where done is raised.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load on phase entry, otherwise decrement until zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road intersection sequencer. Walks NS green/yellow, EW green/yellow,
// optionally a pedestrian phase, and can stop gracefully back to idle.
// Phase lengths come from runtime-programmable duration registers.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int W      = 8,
  parameter int T_NSG  = 8,
  parameter int T_NSY  = 3,
  parameter int T_EWG  = 8,
  parameter int T_EWY  = 3,
  parameter int T_WALK = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  traffic_sequencer_if.slave  bus
);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] dur_q [4];
  logic         stop_q;
  logic         ped_q;
  logic [2:0]   ns_q;
  logic [2:0]   ew_q;
  logic         walk_q;
  logic         done;
  logic         load;
  logic [W-1:0] load_val;

  // A programmed duration of zero behaves as one cycle, so the load
  // value saturates at zero instead of wrapping.
  function automatic logic [W-1:0] minus_one(input logic [W-1:0] d);
    return (d == '0) ? '0 : d - W'(1);
  endfunction

  // Next phase selection; every transition is a state change, so the
  // timer is reloaded exactly when the state differs from the current one
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_NSG;
      ST_NSG:  if (done) state_d = ST_NSY;
      ST_NSY:  if (done) state_d = ST_EWG;
      ST_EWG:  if (done) state_d = ST_EWY;
      ST_EWY:  if (done) state_d = stop_q ? ST_IDLE : (ped_q ? ST_PED : ST_NSG);
      ST_PED:  if (done) state_d = stop_q ? ST_IDLE : ST_NSG;
      default: state_d = ST_IDLE;
    endcase
    load = (state_d != state_q);
  end

  // Timer load value for the phase being entered, read from the duration
  // registers before any same-cycle write lands
  always_comb begin
    load_val = '0;
    case (state_d)
      ST_NSG:  load_val = minus_one(dur_q[CFG_NSG]);
      ST_NSY:  load_val = minus_one(dur_q[CFG_NSY]);
      ST_EWG:  load_val = minus_one(dur_q[CFG_EWG]);
      ST_EWY:  load_val = minus_one(dur_q[CFG_EWY]);
      ST_PED:  load_val = minus_one(W'(T_WALK));
      default: load_val = '0;
    endcase
  end

  phase_timer #(.W(W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .done  (done)
  );

  // Phase register with lamps decoded from the next phase and registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      walk_q  <= 1'b0;
      case (state_d)
        ST_NSG:  ns_q   <= LAMP_GRN;
        ST_NSY:  ns_q   <= LAMP_YEL;
        ST_EWG:  ew_q   <= LAMP_GRN;
        ST_EWY:  ew_q   <= LAMP_YEL;
        ST_PED:  walk_q <= 1'b1;
        default: walk_q <= 1'b0;
      endcase
    end
  end

  // Stop and pedestrian request latches; a fresh ped_req beats the clear
  // on PED entry, and stop is meaningless once idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
      ped_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || state_d == ST_IDLE) begin
        stop_q <= 1'b0;
      end else if (bus.stop) begin
        stop_q <= 1'b1;
      end
      if (bus.ped_req) begin
        ped_q <= 1'b1;
      end else if (load && state_d == ST_PED) begin
        ped_q <= 1'b0;
      end
    end
  end

  // Duration registers, writable at any time; only read at phase entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q[CFG_NSG] <= W'(T_NSG);
      dur_q[CFG_NSY] <= W'(T_NSY);
      dur_q[CFG_EWG] <= W'(T_EWG);
      dur_q[CFG_EWY] <= W'(T_EWY);
    end else if (bus.cfg_we) begin
      dur_q[bus.cfg_sel] <= bus.cfg_val;
    end
  end

  assign bus.phase       = state_q;
  assign bus.ns_light    = ns_q;
  assign bus.ew_light    = ew_q;
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for the intersection sequencer: default cycle, pedestrian
// service, reprogramming, zero duration, stop with pending pedestrian and
// mid-phase reset. Outputs are sampled on the falling clock edge.
module tb_traffic_sequencer;

  localparam logic [2:0] P_IDLE = 3'b000;
  localparam logic [2:0] P_NSG  = 3'b001;
  localparam logic [2:0] P_NSY  = 3'b010;
  localparam logic [2:0] P_EWG  = 3'b011;
  localparam logic [2:0] P_EWY  = 3'b100;
  localparam logic [2:0] P_PED  = 3'b101;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YEL    = 3'b010;
  localparam logic [2:0] GRN    = 3'b001;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  traffic_sequencer_if #(.W(8)) bus ();

  traffic_sequencer #(
    .W(8), .T_NSG(8), .T_NSY(3), .T_EWG(8), .T_EWY(3), .T_WALK(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle pulse/write starting at the current falling edge
  task automatic applyStimulus(input logic ped, input logic stp, input logic we,
                               input logic [1:0] sel, input logic [7:0] val);
    bus.ped_req = ped;
    bus.stop    = stp;
    bus.cfg_we  = we;
    bus.cfg_sel = sel;
    bus.cfg_val = val;
    @(negedge clk);
    bus.ped_req = 1'b0;
    bus.stop    = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_sel = 2'd0;
    bus.cfg_val = 8'd0;
  endtask

  // Compare every output against the expected values at this instant
  task automatic checkOutput(input string tag, input logic [2:0] e_phase,
                             input logic [2:0] e_ns, input logic [2:0] e_ew,
                             input logic e_walk, input logic e_ped);
    checks++;
    assert (bus.phase === e_phase) else begin
      errors++;
      $error("[TB] FAIL %s phase: got %b want %b", tag, bus.phase, e_phase);
    end
    checks++;
    assert (bus.ns_light === e_ns) else begin
      errors++;
      $error("[TB] FAIL %s ns_light: got %b want %b", tag, bus.ns_light, e_ns);
    end
    checks++;
    assert (bus.ew_light === e_ew) else begin
      errors++;
      $error("[TB] FAIL %s ew_light: got %b want %b", tag, bus.ew_light, e_ew);
    end
    checks++;
    assert (bus.walk === e_walk) else begin
      errors++;
      $error("[TB] FAIL %s walk: got %b want %b", tag, bus.walk, e_walk);
    end
    checks++;
    assert (bus.ped_pending === e_ped) else begin
      errors++;
      $error("[TB] FAIL %s ped_pending: got %b want %b", tag, bus.ped_pending, e_ped);
    end
  endtask

  // Count samples the phase stays at e_phase (bounded), leave at the first
  // sample of whatever follows, and compare against the expected length
  task automatic measurePhase(input string tag, input logic [2:0] e_phase,
                              input int e_len, input int limit);
    int n;
    n = 0;
    while (bus.phase === e_phase && n < limit) begin
      n++;
      @(negedge clk);
    end
    checks++;
    assert (n === e_len) else begin
      errors++;
      $error("[TB] FAIL %s length of phase %b: got %0d want %0d", tag, e_phase, n, e_len);
    end
  endtask

  // Linear directed sequence
  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.ped_req = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_sel = 2'd0;
    bus.cfg_val = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset", P_IDLE, RED, RED, 1'b0, 1'b0);

    rst_n = 1'b1;
    measurePhase("idle_nostart", P_IDLE, 3, 3);
    bus.start = 1'b1;
    @(negedge clk);

    // Default cycle
    checkOutput("nsg1", P_NSG, GRN, RED, 1'b0, 1'b0);
    measurePhase("nsg1", P_NSG, 8, 300);
    checkOutput("nsy1", P_NSY, YEL, RED, 1'b0, 1'b0);
    measurePhase("nsy1", P_NSY, 3, 300);
    checkOutput("ewg1", P_EWG, RED, GRN, 1'b0, 1'b0);
    measurePhase("ewg1", P_EWG, 8, 300);
    checkOutput("ewy1", P_EWY, RED, YEL, 1'b0, 1'b0);
    measurePhase("ewy1", P_EWY, 3, 300);

    // Pedestrian request during NSG
    checkOutput("nsg2", P_NSG, GRN, RED, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("nsg2_ped", P_NSG, GRN, RED, 1'b0, 1'b1);
    measurePhase("nsg2", P_NSG, 7, 300);
    measurePhase("nsy2", P_NSY, 3, 300);
    measurePhase("ewg2", P_EWG, 8, 300);
    checkOutput("ewy2", P_EWY, RED, YEL, 1'b0, 1'b1);
    measurePhase("ewy2", P_EWY, 3, 300);
    checkOutput("ped2", P_PED, RED, RED, 1'b1, 1'b0);
    measurePhase("ped2", P_PED, 5, 300);

    // Reprogram NSG to 2 mid-phase
    checkOutput("nsg3", P_NSG, GRN, RED, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
    measurePhase("nsg3_current", P_NSG, 7, 300);
    measurePhase("nsy3", P_NSY, 3, 300);
    measurePhase("ewg3", P_EWG, 8, 300);
    measurePhase("ewy3", P_EWY, 3, 300);
    measurePhase("nsg4_reprog", P_NSG, 2, 300);

    // Zero duration on NSY, written during NSY
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'd0);
    measurePhase("nsy4_current", P_NSY, 2, 300);
    measurePhase("ewg4", P_EWG, 8, 300);
    measurePhase("ewy4", P_EWY, 3, 300);
    measurePhase("nsg5", P_NSG, 2, 300);
    measurePhase("nsy5_zero", P_NSY, 1, 300);

    // Stop and pedestrian together during EWG
    bus.start = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    measurePhase("ewg5", P_EWG, 7, 300);
    checkOutput("ewy5", P_EWY, RED, YEL, 1'b0, 1'b1);
    measurePhase("ewy5", P_EWY, 3, 300);
    checkOutput("idle_stop", P_IDLE, RED, RED, 1'b0, 1'b1);
    measurePhase("idle_hold", P_IDLE, 10, 10);

    // Restart: pending pedestrian is served, stop latch was cleared
    bus.start = 1'b1;
    @(negedge clk);
    checkOutput("nsg6", P_NSG, GRN, RED, 1'b0, 1'b1);
    measurePhase("nsg6", P_NSG, 2, 300);
    measurePhase("nsy6", P_NSY, 1, 300);
    measurePhase("ewg6", P_EWG, 8, 300);
    measurePhase("ewy6", P_EWY, 3, 300);
    checkOutput("ped6", P_PED, RED, RED, 1'b1, 1'b0);
    measurePhase("ped6", P_PED, 5, 300);
    measurePhase("nsg7", P_NSG, 2, 300);
    measurePhase("nsy7", P_NSY, 1, 300);

    // Reset mid-EWG with a request pending
    checkOutput("ewg7", P_EWG, RED, GRN, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid", P_IDLE, RED, RED, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("nsg8", P_NSG, GRN, RED, 1'b0, 1'b0);
    measurePhase("nsg8_default", P_NSG, 8, 300);
    measurePhase("nsy8_default", P_NSY, 3, 300);
    checkOutput("ewg8", P_EWG, RED, GRN, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
